// File: rtl/ps2_dev_tx.sv
// PS/2 device-to-host byte transmitter: frames one scan-code byte as start, 8 data bits LSB
// first, odd parity and stop, generating the PS/2 clock itself and honouring host inhibit.
module ps2_dev_tx #(
    parameter int unsigned HALF = 4,
    parameter int unsigned GAP  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    input  logic       inhibit,
    output logic       ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       done,
    output logic       abort
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow, StGap} state_e;

    localparam logic [15:0] HalfLast = 16'(HALF - 1);
    localparam logic [15:0] GapLast  = 16'(GAP - 1);
    localparam logic [3:0]  LastBit  = 4'd10;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  bit_q;
    logic [9:0]  shift_q;  // bits 1..10 of the frame still to be sent, LSB next
    logic        ps2_clk_q;
    logic        ps2_data_q;
    logic        done_q;
    logic        abort_q;

    logic accept;
    logic cut;

    // ready follows inhibit in the same cycle so a simultaneous valid is refused
    assign ready  = (state_q == StIdle) && !inhibit;
    assign accept = valid && ready;
    assign cut    = inhibit && ((state_q == StHigh) || (state_q == StLow));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (cut) begin
                state_q    <= StIdle;
                cnt_q      <= '0;
                bit_q      <= '0;
                ps2_clk_q  <= 1'b1;
                ps2_data_q <= 1'b1;
                abort_q    <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            state_q    <= StHigh;
                            cnt_q      <= '0;
                            bit_q      <= '0;
                            shift_q    <= {1'b1, ~^data, data};
                            ps2_clk_q  <= 1'b1;
                            ps2_data_q <= 1'b0;
                        end
                    end
                    StHigh: begin
                        if (cnt_q == HalfLast) begin
                            state_q   <= StLow;
                            cnt_q     <= '0;
                            ps2_clk_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    StLow: begin
                        if (cnt_q == HalfLast) begin
                            cnt_q     <= '0;
                            ps2_clk_q <= 1'b1;
                            if (bit_q == LastBit) begin
                                state_q    <= StGap;
                                ps2_data_q <= 1'b1;
                                done_q     <= 1'b1;
                            end else begin
                                // data only moves here, at the start of a high phase
                                state_q    <= StHigh;
                                bit_q      <= bit_q + 4'd1;
                                ps2_data_q <= shift_q[0];
                                shift_q    <= {1'b1, shift_q[9:1]};
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    StGap: begin
                        if (cnt_q == GapLast) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;
    assign done     = done_q;
    assign abort    = abort_q;

    a_done_abort_excl: assert property (@(posedge clk) !(done && abort));

    a_data_stable_low: assert property (@(posedge clk) disable iff (!rst)
        (!ps2_clk && !$past(ps2_clk)) |-> (ps2_data == $past(ps2_data)));

    a_bit_range: assert property (@(posedge clk) disable iff (!rst) bit_q <= LastBit);

endmodule

// File: doc/ps2_dev_tx.md
PS2_DEV_TX -- requirements
Module: ps2_dev_tx

Interface
REQ-001 SHALL have parameter HALF, default 4, meaning clk cycles per PS/2 clock half-period (legal range 1..65535).
REQ-002 SHALL have parameter GAP, default 8, meaning idle clk cycles enforced after each completed frame (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-005 SHALL have port valid  input  1  request to send the byte on data.
REQ-006 SHALL have port data  input  8  scan-code byte, sampled only on acceptance.
REQ-007 SHALL have port inhibit  input  1  host inhibit (host holding PS/2 clock low); 1 = inhibited.
REQ-008 SHALL have port ready  output  1  1 = a byte can be accepted this cycle.
REQ-009 SHALL have port ps2_clk  output  1  PS/2 clock line driven by the device.
REQ-010 SHALL have port ps2_data  output  1  PS/2 data line driven by the device.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-012 SHALL have port abort  output  1  one-cycle pulse when a frame is cut short by inhibit.

Function
REQ-013 SHALL implement states IDLE, HIGH, LOW, GAP, all outputs registered.
REQ-014 ready SHALL equal 1 only in IDLE with inhibit=0.
REQ-015 Acceptance SHALL occur on a cycle with valid=1 and ready=1; data latched, odd parity computed (parity bit = 1 when data has an even number of ones).
REQ-016 Frame SHALL be 11 bits in order: start 0, data[0]..data[7], parity, stop 1.
REQ-017 On the cycle after acceptance, state SHALL be HIGH for bit 0, ps2_data = bit value, ps2_clk = 1.
REQ-018 Each bit SHALL occupy HIGH for HALF cycles (ps2_clk=1) then LOW for HALF cycles (ps2_clk=0); ps2_data SHALL change only at the start of HIGH, never while ps2_clk=0.
REQ-019 After LOW of bit 10, state SHALL go to GAP with ps2_clk=1, ps2_data=1, done=1 for that first GAP cycle only; frame length from first HIGH cycle to done = exactly 22*HALF cycles.
REQ-020 GAP SHALL last GAP cycles, then IDLE; valid during HIGH/LOW/GAP SHALL be ignored (not queued).
REQ-021 In IDLE, ps2_clk=1 and ps2_data=1.
REQ-022 inhibit=1 during HIGH or LOW SHALL, on the next cycle, force ps2_clk=1, ps2_data=1, abort=1 for one cycle, and go to IDLE; the byte is dropped; done SHALL not pulse.
REQ-023 inhibit=1 during GAP SHALL not abort; GAP completes normally.
REQ-024 inhibit and valid rising in the same IDLE cycle SHALL not accept (ready=0).
REQ-025 Internal bit index 0..10 and half-period/gap counters (16-bit) SHALL not wrap mid-frame; index resets to 0 on every acceptance.
REQ-026 done and abort SHALL never be 1 in the same cycle.

Reset
REQ-027 While rst=0 at a clock edge: state IDLE, ps2_clk=1, ps2_data=1, done=0, abort=0, counters 0; ready=1 on the first cycle after rst=1 if inhibit=0.
REQ-028 rst=0 mid-frame SHALL abort without an abort pulse; lines high next cycle.

Verification
REQ-029 HALF=4, send 0x1C -> ps2_data sampled at each ps2_clk fall = 0,0,0,1,1,1,0,0,0,0,1; done exactly 88 cycles after first HIGH cycle.
REQ-030 Send 0xF0 then 0xFF back-to-back with valid held -> parity bits 1 and 1; second frame starts exactly GAP+1 cycles after done.
REQ-031 Send 0x01, assert inhibit during LOW of bit 4 -> next cycle ps2_clk=1, ps2_data=1, abort=1, no done; ready=1 once inhibit drops.
REQ-032 valid pulsed with data=0x55 during a frame in progress -> ignored; only the original byte is transmitted.
REQ-033 rst=0 during bit 6 of 0x00 -> next cycle lines high, done=0, abort=0; after rst=1, ready=1 and a new 0x00 frame sends parity 1.
REQ-034 HALF=1, GAP=1, send 0xA5 -> ps2_clk toggles every cycle, frame 22 cycles, parity bit 1, data never changes while ps2_clk=0.
